axilite_slave_regfile: RTL
==========================

Name: axilite_slave_regfile

Overview:
AXI4-lite responder, i.e. the register bank that sits on one downstream port of axilite_interconnect.
- Accepts write and read transactions on the offset address the interconnect forwards.
- Provides NUM_REGS 32-bit control/status registers.
- Returns OKAY/SLVERR responses.
- Exposes register contents and write-strobe pulses to local logic.

Parameters:
NUM_REGS, 16, number of 32-bit registers (2..64, power of two not required)
ADDR_WIDTH, 32, width of the s_axi_awaddr/s_axi_araddr offset
RESET_VALUE, 32'h0000_0000, reset value of every RW register
RO_MASK, 64'h0, bit i = 1 makes register i read-only (value taken from ro_data)

Ports:
s_axi_aclk  in  1  clock
s_axi_aresetn  in  1  asynchronous active-low reset
s_axi_awaddr  in  ADDR_WIDTH  write byte offset
s_axi_awprot  in  3  accepted, ignored
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte strobes
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  ADDR_WIDTH  read byte offset
s_axi_arprot  in  3  accepted, ignored
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
reg_q  out  NUM_REGS*32  flat register contents, reg i at [i*32+:32]
reg_wr_pulse  out  NUM_REGS  1-cycle pulse on successful write to reg i
ro_data  in  NUM_REGS*32  source for read-only registers

Behaviour:
- Reset (async assert, sync release):
  - RW regs = RESET_VALUE; bvalid = rvalid = 0; bresp = rresp = 0; rdata = 0; reg_wr_pulse = 0; holding buffers empty.
  - awready/wready/arready are driven from a registered rst_done flag: 0 while reset is asserted, 1 from the first edge after release.
- Decode: index = addr[2 +: clog2(NUM_REGS)]; addr[1:0] ignored.
  - addr >= NUM_REGS*4 -> out of range.
- Write path: AW and W each have a one-entry holding buffer and are accepted independently, in any order or the same cycle.
  - awready = rst_done & !aw_full; wready = rst_done & !w_full.
  - Commit condition: aw_full & w_full & (!bvalid | bready).
  - On the commit edge: bytes with wstrb[k]=1 are written to byte k of the target reg; both buffers clear; bvalid <= 1; reg_wr_pulse[index] <= 1 for one cycle.
  - AW+W handshake at edge N -> register updated and bvalid high after edge N+1.
  - bvalid held with bresp stable until bready; cleared on the handshake edge unless a new commit happens at that same edge.
  - New AW/W may be accepted while B is pending (buffers already cleared).
  - bresp = 2'b00 OKAY on success.
  - bresp = 2'b10 SLVERR when out of range or the target is read-only; no register change and no pulse in that case.
  - wstrb = 4'b0000 -> OKAY, no change, pulse still asserted.
- Read path: arready = rst_done & (!rvalid | rready).
  - AR handshake at edge N -> rdata/rresp registered, rvalid high after edge N.
  - rvalid held with rdata/rresp stable until rready.
  - Back-to-back reads with rready held high: one read per cycle.
  - RO reg -> rdata = ro_data slice. RW reg -> stored value. Out of range -> rdata 0, rresp SLVERR.
- Simultaneous read and commit to the same register on the same edge: the read returns the pre-write value.
- Reads and writes are fully independent; there is no ordering between channels.
- reg_q for RO indices mirrors ro_data; for RW indices it shows the stored value.
- Reset mid-transaction: pending buffers, bvalid and rvalid are dropped; no response is issued after reset release.

Decomposition:
- Package axilite_pkg:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - AXIL_DATA_W = 32, AXIL_STRB_W = 4.
  - typedef axil_resp_t (logic [1:0]).
  - function byte_merge(old, new, strb).
- One sub-module, axilite_hold_reg: single-entry valid/ready holding buffer (parameterized width, full flag, load/clear), instantiated for AW (addr) and W (data+strb).

Test Plan:
- Reset then AW 0x08 and W 0xDEADBEEF with strb 4'hF in the same cycle, bready=1 -> bvalid one cycle after the handshake, bresp 00, reg_q[2] = 0xDEADBEEF, reg_wr_pulse[2] pulses once; read 0x08 -> rdata 0xDEADBEEF, rresp 00.
- W (0x12345678, strb 4'b0101) three cycles before AW 0x04, reg 1 previously 0xAAAAAAAA -> reg 1 = 0xAA34AA78, single B response.
- Write 0x40 with NUM_REGS=16 -> bresp 10, no reg_q change; read 0x40 -> rdata 0, rresp 10.
- RO_MASK bit3=1, ro_data[3]=0xCAFE0003; write 0x0C -> bresp 10; read 0x0C -> 0xCAFE0003, rresp 00.
- bready held low 5 cycles with a second AW/W queued -> bvalid/bresp stable, second AW/W accepted, second commit only on the edge bready=1, then second bvalid; 4 back-to-back reads with rready=1 -> 4 consecutive rvalid cycles.
- Assert aresetn=0 while bvalid=1 and AW buffered -> bvalid 0 immediately, readies 0; after release, no stale B, regs = RESET_VALUE.

Source files
------------

// File: rtl/axilite_pkg.sv
// Shared AXI4-lite constants, response type and the byte-lane merge helper.
package axilite_pkg;

  localparam int AXIL_DATA_W = 32;
  localparam int AXIL_STRB_W = 4;

  typedef logic [1:0] axil_resp_t;

  localparam axil_resp_t RESP_OKAY   = 2'b00;
  localparam axil_resp_t RESP_SLVERR = 2'b10;

  // Replace each byte lane of old_v whose strobe bit is set with the lane from new_v.
  function automatic logic [AXIL_DATA_W-1:0] byte_merge(
    input logic [AXIL_DATA_W-1:0] old_v,
    input logic [AXIL_DATA_W-1:0] new_v,
    input logic [AXIL_STRB_W-1:0] strb
  );
    logic [AXIL_DATA_W-1:0] res_v;
    res_v = old_v;
    for (int k = 0; k < AXIL_STRB_W; k++) begin
      if (strb[k]) begin
        res_v[k*8 +: 8] = new_v[k*8 +: 8];
      end else begin
        res_v[k*8 +: 8] = old_v[k*8 +: 8];
      end
    end
    return res_v;
  endfunction

endpackage

// File: rtl/axilite_hold_reg.sv
// Single-entry holding buffer: captures a payload on load, reports full until cleared.
module axilite_hold_reg
  import axilite_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             full
);

  logic [WIDTH-1:0] data_r;
  logic             full_r;

  // Capture payload on load; clear takes priority so a consumed entry is freed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= {WIDTH{1'b0}};
      full_r <= 1'b0;
    end else if (clear) begin
      full_r <= 1'b0;
    end else if (load) begin
      data_r <= d;
      full_r <= 1'b1;
    end
  end

  assign q    = data_r;
  assign full = full_r;

endmodule

// File: rtl/axilite_slave_regfile.sv
// AXI4-lite register bank: NUM_REGS 32-bit RW/RO registers with OKAY/SLVERR responses.
module axilite_slave_regfile
  import axilite_pkg::*;
#(
  parameter int          NUM_REGS    = 16,
  parameter int          ADDR_WIDTH  = 32,
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000,
  parameter logic [63:0] RO_MASK     = 64'h0
) (
  input  logic                     s_axi_aclk,
  input  logic                     s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]    s_axi_awaddr,
  input  logic [2:0]               s_axi_awprot,
  input  logic                     s_axi_awvalid,
  output logic                     s_axi_awready,
  input  logic [31:0]              s_axi_wdata,
  input  logic [3:0]               s_axi_wstrb,
  input  logic                     s_axi_wvalid,
  output logic                     s_axi_wready,
  output logic [1:0]               s_axi_bresp,
  output logic                     s_axi_bvalid,
  input  logic                     s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]    s_axi_araddr,
  input  logic [2:0]               s_axi_arprot,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [31:0]              s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
  output logic [NUM_REGS*32-1:0]   reg_q,
  output logic [NUM_REGS-1:0]      reg_wr_pulse,
  input  logic [NUM_REGS*32-1:0]   ro_data
);

  localparam int                    IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);
  localparam logic [NUM_REGS-1:0]   RO_BITS    = RO_MASK[NUM_REGS-1:0];

  logic                  rst_done_r;
  logic                  aw_full_s;
  logic                  w_full_s;
  logic                  aw_load_s;
  logic                  w_load_s;
  logic                  commit_s;
  logic                  ar_hs_s;
  logic [ADDR_WIDTH-1:0] aw_addr_s;
  logic [35:0]           w_hold_s;
  logic [IDX_W-1:0]      aw_idx_s;
  logic [IDX_W-1:0]      ar_idx_s;
  logic                  aw_oor_s;
  logic                  ar_oor_s;
  logic                  w_ro_s;
  logic                  w_err_s;
  logic [31:0]           rd_word_s;
  logic [31:0]           regs_r [NUM_REGS];
  logic [31:0]           word_s [NUM_REGS];
  logic                  bvalid_r;
  axil_resp_t            bresp_r;
  logic                  rvalid_r;
  axil_resp_t            rresp_r;
  logic [31:0]           rdata_r;
  logic [NUM_REGS-1:0]   wr_pulse_r;
  logic                  unused_prot_s;

  // Protection bits carry no meaning for this register bank.
  assign unused_prot_s = ^{s_axi_awprot, s_axi_arprot};

  // Ready outputs stay low until the first clock edge after reset release.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      rst_done_r <= 1'b0;
    end else begin
      rst_done_r <= 1'b1;
    end
  end

  assign s_axi_awready = rst_done_r & ~aw_full_s;
  assign s_axi_wready  = rst_done_r & ~w_full_s;
  assign s_axi_arready = rst_done_r & (~rvalid_r | s_axi_rready);

  assign aw_load_s = s_axi_awvalid & s_axi_awready;
  assign w_load_s  = s_axi_wvalid & s_axi_wready;
  assign commit_s  = aw_full_s & w_full_s & (~bvalid_r | s_axi_bready);
  assign ar_hs_s   = s_axi_arvalid & s_axi_arready;

  axilite_hold_reg #(.WIDTH(ADDR_WIDTH)) u_aw_hold (
    .clk   (s_axi_aclk),
    .rst_n (s_axi_aresetn),
    .load  (aw_load_s),
    .clear (commit_s),
    .d     (s_axi_awaddr),
    .q     (aw_addr_s),
    .full  (aw_full_s)
  );

  axilite_hold_reg #(.WIDTH(36)) u_w_hold (
    .clk   (s_axi_aclk),
    .rst_n (s_axi_aresetn),
    .load  (w_load_s),
    .clear (commit_s),
    .d     ({s_axi_wstrb, s_axi_wdata}),
    .q     (w_hold_s),
    .full  (w_full_s)
  );

  assign aw_idx_s = aw_addr_s[2 +: IDX_W];
  assign ar_idx_s = s_axi_araddr[2 +: IDX_W];
  assign aw_oor_s = (aw_addr_s >= ADDR_LIMIT);
  assign ar_oor_s = (s_axi_araddr >= ADDR_LIMIT);

  // Visible word per index: RO slots mirror ro_data, RW slots show storage.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_word
    assign word_s[g]             = RO_BITS[g] ? ro_data[g*32 +: 32] : regs_r[g];
    assign reg_q[g*32 +: 32]     = word_s[g];
  end

  // Decode read-only status of the write target and the read word.
  always_comb begin
    w_ro_s    = 1'b0;
    rd_word_s = 32'h0000_0000;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_ro_s    = (aw_idx_s == IDX_W'(i)) ? RO_BITS[i] : w_ro_s;
      rd_word_s = (ar_idx_s == IDX_W'(i)) ? word_s[i]  : rd_word_s;
    end
  end

  assign w_err_s = aw_oor_s | w_ro_s;

  // Register storage: merge strobed bytes into the target on a clean commit.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= RESET_VALUE;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit_s && !w_err_s && (aw_idx_s == IDX_W'(i))) begin
          regs_r[i] <= byte_merge(regs_r[i], w_hold_s[31:0], w_hold_s[35:32]);
        end
      end
    end
  end

  // Write response and per-register write pulse, issued on the commit edge.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      bvalid_r   <= 1'b0;
      bresp_r    <= RESP_OKAY;
      wr_pulse_r <= {NUM_REGS{1'b0}};
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        wr_pulse_r[i] <= commit_s & ~w_err_s & (aw_idx_s == IDX_W'(i));
      end
      if (commit_s) begin
        bvalid_r <= 1'b1;
        bresp_r  <= w_err_s ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axi_bready) begin
        bvalid_r <= 1'b0;
      end
    end
  end

  // Read data channel: capture word and response on each AR handshake.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      rvalid_r <= 1'b0;
      rresp_r  <= RESP_OKAY;
      rdata_r  <= 32'h0000_0000;
    end else if (ar_hs_s) begin
      rvalid_r <= 1'b1;
      rresp_r  <= ar_oor_s ? RESP_SLVERR : RESP_OKAY;
      rdata_r  <= ar_oor_s ? 32'h0000_0000 : rd_word_s;
    end else if (s_axi_rready) begin
      rvalid_r <= 1'b0;
    end
  end

  assign s_axi_bvalid = bvalid_r;
  assign s_axi_bresp  = bresp_r;
  assign s_axi_rvalid = rvalid_r;
  assign s_axi_rresp  = rresp_r;
  assign s_axi_rdata  = rdata_r;
  assign reg_wr_pulse = wr_pulse_r;

endmodule
